// File: rtl/fifo_burst_reader_if.sv
// Purpose : stream and FIFO-read signal bundle for fifo_burst_reader.
// Latency : none, wires only.
// Backpressure: m_ready_in stalls the stream; fifo_empty_in stalls FIFO reads.
// Ports (master = reader side):
//   fifo_rd_en_out  out  read request to the upstream FIFO
//   fifo_empty_in   in   upstream FIFO empty flag
//   fifo_data_in    in   upstream FIFO registered read data
//   m_data_out      out  stream data
//   m_valid_out     out  stream data valid
//   m_last_out      out  final word of burst
//   m_ready_in      in   downstream accepts word
interface fifo_burst_reader_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  fifo_rd_en_out;
   logic                  fifo_empty_in;
   logic [DATA_WIDTH-1:0] fifo_data_in;
   logic [DATA_WIDTH-1:0] m_data_out;
   logic                  m_valid_out;
   logic                  m_last_out;
   logic                  m_ready_in;

   modport master (
      output fifo_rd_en_out,
      input  fifo_empty_in,
      input  fifo_data_in,
      output m_data_out,
      output m_valid_out,
      output m_last_out,
      input  m_ready_in
   );

   modport slave (
      input  fifo_rd_en_out,
      output fifo_empty_in,
      output fifo_data_in,
      input  m_data_out,
      input  m_valid_out,
      input  m_last_out,
      output m_ready_in
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Purpose : drain a fixed-length burst from a sync FIFO and stream it out with last marking.
// Latency : start edge -> first m_valid_out 2 cycles later, then 1 word/cycle.
// Backpressure: m_ready_in low holds the output word; reads stop once 3 credits are in use.
// Ports:
//   clk_in, rst_n_in      clock, async active-low reset
//   start_in, burst_len_in  burst request (sampled in IDLE only)
//   busy_out, done_out    status; done_out pulses one cycle at burst end
//   bus (master)          FIFO read side and output stream
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BURST  = 1024,
   parameter int CNT_BITS   = $clog2(MAX_BURST) + 1
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                start_in,
   input  logic [CNT_BITS-1:0] burst_len_in,
   output logic                busy_out,
   output logic                done_out,
   fifo_burst_reader_if.master bus
);

   localparam logic [CNT_BITS-1:0] MAX_LEN = CNT_BITS'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [CNT_BITS-1:0] len_q;
   logic [CNT_BITS-1:0] issued_q;
   logic [CNT_BITS-1:0] sent_q;
   logic                inflight_q;

   logic [DATA_WIDTH-1:0] buf_q [3];
   logic [1:0]            wr_ptr_q;
   logic [1:0]            rd_ptr_q;
   logic [1:0]            buf_cnt_q;

   logic                  rd_en;
   logic                  push;
   logic                  pop;
   logic                  m_valid;
   logic                  m_last;
   logic                  load;
   logic [2:0]            credits_used;

   // Entries already buffered plus the word still coming from the FIFO must
   // leave room, so the unconditional push one cycle later can never overflow.
   assign credits_used = {1'b0, buf_cnt_q} + {2'b00, inflight_q};

   assign rd_en   = (state_q == ACTIVE) && !bus.fifo_empty_in &&
                    (issued_q < len_q) && (credits_used < 3'd3);
   assign push    = inflight_q;
   assign m_valid = (buf_cnt_q != 2'd0);
   assign m_last  = m_valid && (sent_q == len_q - CNT_BITS'(1));
   assign pop     = m_valid && bus.m_ready_in;
   assign load    = (state_q == IDLE) && start_in && (burst_len_in != '0);

   assign bus.fifo_rd_en_out = rd_en;
   assign bus.m_valid_out    = m_valid;
   assign bus.m_last_out     = m_last;
   assign bus.m_data_out     = buf_q[rd_ptr_q];
   assign busy_out           = (state_q != IDLE);
   assign done_out           = (state_q == DONE);

   // ---------------- FSM ----------------
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_in) begin
               state_d = (burst_len_in == '0) ? DONE : ACTIVE;
            end
         end
         ACTIVE: begin
            if (pop && m_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------- burst counters ----------------
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         len_q      <= '0;
         issued_q   <= '0;
         sent_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= rd_en;
         if (load) begin
            len_q    <= (burst_len_in > MAX_LEN) ? MAX_LEN : burst_len_in;
            issued_q <= '0;
            sent_q   <= '0;
         end else begin
            if (rd_en) begin
               issued_q <= issued_q + CNT_BITS'(1);
            end
            if (pop) begin
               sent_q <= sent_q + CNT_BITS'(1);
            end
         end
      end
   end

   // ---------------- 3-entry output buffer ----------------
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < 3; i++) begin
            buf_q[i] <= '0;
         end
         wr_ptr_q  <= 2'd0;
         rd_ptr_q  <= 2'd0;
         buf_cnt_q <= 2'd0;
      end else begin
         if (push) begin
            buf_q[wr_ptr_q] <= bus.fifo_data_in;
            wr_ptr_q        <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
         end
         case ({push, pop})
            2'b10:   buf_cnt_q <= buf_cnt_q + 2'd1;
            2'b01:   buf_cnt_q <= buf_cnt_q - 2'd1;
            default: buf_cnt_q <= buf_cnt_q;
         endcase
      end
   end

endmodule
